// File: rtl/gpio_pkg.sv
// Shared constants for the AHB-Lite GPIO block: byte offsets of every
// register in the map and the value returned for unmapped offsets.
package gpio_pkg;

  localparam logic [7:0] OFS_DIN     = 8'h00;
  localparam logic [7:0] OFS_DOUT    = 8'h04;
  localparam logic [7:0] OFS_DOUTSET = 8'h08;
  localparam logic [7:0] OFS_DOUTCLR = 8'h0C;
  localparam logic [7:0] OFS_DOUTTGL = 8'h10;
  localparam logic [7:0] OFS_PU      = 8'h14;
  localparam logic [7:0] OFS_PD      = 8'h18;
  localparam logic [7:0] OFS_DIR     = 8'h1C;
  localparam logic [7:0] OFS_IM      = 8'h20;
  localparam logic [7:0] OFS_ITYPE   = 8'h24;
  localparam logic [7:0] OFS_IPOL    = 8'h28;
  localparam logic [7:0] OFS_IBOTH   = 8'h2C;
  localparam logic [7:0] OFS_RIS     = 8'h30;
  localparam logic [7:0] OFS_MIS     = 8'h34;
  localparam logic [7:0] OFS_ICR     = 8'h38;

  localparam logic [31:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;

endpackage

// File: rtl/gpio_sync_edge.sv
// One-pin input synchroniser followed by a "previous" flop for edge detect.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   pin_i         : raw asynchronous pin
//   sync_o        : synchronised pin value (chain output)
//   rise_o/fall_o : one-cycle pulses when sync_o differs from its previous value
module gpio_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/ahblite_gpio_irq.sv
// AHB-Lite GPIO slave with per-pin level/edge interrupts.
// Ports:
//   HCLK, HRESETn             : clock, asynchronous active-low reset
//   HSEL..HWDATA              : AHB-Lite slave address/data-phase inputs
//   HRDATA, HREADYOUT, HRESP  : read data, always-ready, always-OKAY
//   GPIODIN                   : raw asynchronous pins
//   GPIODOUT/PU/PD/DIR        : pin output value, pull-up, pull-down, direction
//   IRQ, IRQ_ANY              : per-pin masked status and its OR
module ahblite_gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [6:2]       HADDR,
  input  logic             HREADY,
  input  logic             HWRITE,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic [1:0]       HRESP,
  input  logic [WIDTH-1:0] GPIODIN,
  output logic [WIDTH-1:0] GPIODOUT,
  output logic [WIDTH-1:0] GPIOPU,
  output logic [WIDTH-1:0] GPIOPD,
  output logic [WIDTH-1:0] GPIODIR,
  output logic [WIDTH-1:0] IRQ,
  output logic             IRQ_ANY
);

  logic       sel_q, write_q, trans_q;
  logic [4:0] addr_q;

  logic [WIDTH-1:0] dout_q, dout_d, pu_q, pd_q, dir_q;
  logic [WIDTH-1:0] im_q, itype_q, ipol_q, iboth_q;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] sync, rise, fall;
  logic [WIDTH-1:0] edge_set, edge_clr, level, ris, mis, wdata;

  logic       dphase, wr_en;
  logic [7:0] ofs;

  // Every access is a full word; size, sequential/non-seq and high data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{HSIZE, HTRANS[0], HWDATA};

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i (HCLK),
      .rst_ni(HRESETn),
      .pin_i (GPIODIN[g]),
      .sync_o(sync[g]),
      .rise_o(rise[g]),
      .fall_o(fall[g])
    );
  end

  assign dphase = sel_q & trans_q;
  assign wr_en  = dphase & write_q;
  assign ofs    = {1'b0, addr_q, 2'b00};
  assign wdata  = HWDATA[WIDTH-1:0];

  always_comb begin
    dout_d = dout_q;
    if (wr_en) begin
      case (ofs)
        OFS_DOUT:    dout_d = wdata;
        OFS_DOUTSET: dout_d = dout_q | wdata;
        OFS_DOUTCLR: dout_d = dout_q & ~wdata;
        OFS_DOUTTGL: dout_d = dout_q ^ wdata;
        default:     dout_d = dout_q;
      endcase
    end
  end

  // Sticky edge status: a new event always wins over a same-cycle clear.
  // Rewriting ITYPE drops status of every bit whose mode actually changes.
  always_comb begin
    edge_set = itype_q & ~dir_q &
               ((iboth_q & (rise | fall)) |
                (~iboth_q & ipol_q & rise) |
                (~iboth_q & ~ipol_q & fall));
    edge_clr = '0;
    if (wr_en && ofs == OFS_ICR)   edge_clr = wdata;
    if (wr_en && ofs == OFS_ITYPE) edge_clr = wdata ^ itype_q;
    edge_d = edge_set | (edge_q & ~edge_clr);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      trans_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      pu_q    <= '0;
      pd_q    <= '0;
      dir_q   <= '0;
      im_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      edge_q  <= '0;
    end else begin
      sel_q   <= HSEL & HREADY;
      write_q <= HWRITE;
      trans_q <= HTRANS[1];
      addr_q  <= HADDR;
      dout_q  <= dout_d;
      edge_q  <= edge_d;
      if (wr_en) begin
        case (ofs)
          OFS_PU:    pu_q    <= wdata;
          OFS_PD:    pd_q    <= wdata;
          OFS_DIR:   dir_q   <= wdata;
          OFS_IM:    im_q    <= wdata;
          OFS_ITYPE: itype_q <= wdata;
          OFS_IPOL:  ipol_q  <= wdata;
          OFS_IBOTH: iboth_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign level = ~(sync ^ ipol_q) & ~dir_q;
  assign ris   = (itype_q & edge_q) | (~itype_q & level);
  assign mis   = ris & im_q;

  always_comb begin
    HRDATA = '0;
    if (dphase) begin
      case (ofs)
        OFS_DIN:     HRDATA = 32'(sync);
        OFS_DOUT:    HRDATA = 32'(dout_q);
        OFS_DOUTSET: HRDATA = '0;
        OFS_DOUTCLR: HRDATA = '0;
        OFS_DOUTTGL: HRDATA = '0;
        OFS_PU:      HRDATA = 32'(pu_q);
        OFS_PD:      HRDATA = 32'(pd_q);
        OFS_DIR:     HRDATA = 32'(dir_q);
        OFS_IM:      HRDATA = 32'(im_q);
        OFS_ITYPE:   HRDATA = 32'(itype_q);
        OFS_IPOL:    HRDATA = 32'(ipol_q);
        OFS_IBOTH:   HRDATA = 32'(iboth_q);
        OFS_RIS:     HRDATA = 32'(ris);
        OFS_MIS:     HRDATA = 32'(mis);
        OFS_ICR:     HRDATA = '0;
        default:     HRDATA = RDATA_UNMAPPED;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign GPIODOUT  = dout_q;
  assign GPIOPU    = pu_q;
  assign GPIOPD    = pd_q;
  assign GPIODIR   = dir_q;
  assign IRQ       = mis;
  assign IRQ_ANY   = |mis;

endmodule

// File: doc/ahblite_gpio_irq.md
AHBLITE_GPIO_IRQ -- requirements
Module: ahblite_gpio_irq

Interface
REQ-001 SHALL have parameter WIDTH, 16, number of GPIO pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, 2, input synchroniser depth (2 or 3).
REQ-003 SHALL have ports HCLK input 1 (the single clock) and HRESETn input 1 (asynchronous, active-low reset).
REQ-004 SHALL have the AHB-Lite slave inputs: HSEL 1, HADDR[6:2] 5 (word offset), HREADY 1, HWRITE 1, HTRANS 2, HSIZE 3, HWDATA 32.
REQ-005 SHALL have the AHB-Lite slave outputs: HRDATA 32, HREADYOUT 1 (constant 1), HRESP 2 (constant 0).
REQ-006 SHALL have pin-side ports: GPIODIN input WIDTH (raw asynchronous pins), and outputs GPIODOUT, GPIOPU, GPIOPD and GPIODIR, each WIDTH.
REQ-007 SHALL have interrupt outputs IRQ output WIDTH (per-pin masked status) and IRQ_ANY output 1 (OR of IRQ).

Function
REQ-008 SHALL register HSEL&HREADY, HADDR[6:2], HWRITE and HTRANS[1] at the address phase; the data phase is active when the registered select and HTRANS[1] are both 1.
REQ-009 SHALL commit a data-phase write on the clock edge that ends that data phase; every access is treated as a full 32-bit word regardless of HSIZE, and bits above WIDTH are ignored.
REQ-010 SHALL drive HRDATA combinationally during the data phase from the registered offset; unused bits read 0 and unmapped offsets read 0xDEADBEEF.
REQ-011 SHALL implement this register map:
- 0x00 DIN: RO; synchronised pin value.
- 0x04 DOUT: RW.
- 0x08 DOUTSET, 0x0C DOUTCLR, 0x10 DOUTTGL: WO, read 0; each 1 bit sets, clears or toggles the matching DOUT bit.
- 0x14 PU, 0x18 PD, 0x1C DIR: RW; DIR 1 means output.
- 0x20 IM: RW; interrupt mask.
- 0x24 ITYPE: RW; 0 selects level, 1 selects edge.
- 0x28 IPOL: RW; 1 selects high/rising, 0 selects low/falling.
- 0x2C IBOTH: RW; when 1 in edge mode, either edge triggers.
- 0x30 RIS: RO; raw status.
- 0x34 MIS: RO; RIS&IM.
- 0x38 ICR: WO, read 0; write 1 clears the edge status bit.
REQ-012 SHALL pass each pin through a SYNC_STAGES flop chain followed by one "previous" flop; DIN reads the chain output, so a pin change is visible in DIN SYNC_STAGES edges after it is first sampled.
REQ-013 SHALL set an edge status bit on the edge SYNC_STAGES+1 after the pin change is first sampled, when ITYPE=1, DIR=0 and the edge matches IPOL/IBOTH; the bit stays set until cleared by ICR.
REQ-014 SHALL make a level-mode RIS bit equal (sync value == IPOL) & ~DIR, non-sticky; ICR has no effect on it.
REQ-015 SHALL let the set win when an edge event and an ICR clear of the same bit coincide in one cycle.
REQ-016 SHALL clear the edge status of the affected bits when ITYPE is written, so no stale status remains across a mode change.
REQ-017 SHALL drive IRQ = MIS and IRQ_ANY = |MIS, both combinational from registers, with no added latency.
REQ-018 SHALL ignore a data-phase write whose registered select or HTRANS[1] is 0; IDLE and BUSY transfers change nothing.

Reset
REQ-019 SHALL, on HRESETn low, asynchronously clear to 0: all registers, the synchroniser and previous flops, the status bits and the registered address-phase signals.
REQ-020 SHALL, while in reset, drive GPIODOUT, GPIOPU, GPIOPD, GPIODIR, IRQ and IRQ_ANY to 0; HREADYOUT stays 1.
REQ-021 SHALL, if reset is asserted mid-transfer, abort the pending write without committing it and clear all pending edge status.

Structure
REQ-022 SHALL place the register offset constants (0x00–0x38) and the DEADBEEF default in the shared package gpio_pkg.
REQ-023 SHALL put one synchroniser-plus-edge-detector per pin in sub-module gpio_sync_edge, instantiated WIDTH times.

Verification
REQ-024 SHALL check: write DOUT=0x00F0, then DOUTSET=0x000F, DOUTCLR=0x0030, DOUTTGL=0x0101 -> DOUT reads 0x01CE and GPIODOUT=0x01CE.
REQ-025 SHALL check: DIR=0, ITYPE=1, IPOL=1, IM=0x0004, pin2 rising -> RIS[2]=1 exactly SYNC_STAGES+1 edges after sampling, IRQ_ANY=1; write ICR=0x0004 -> IRQ_ANY=0.
REQ-026 SHALL check: IBOTH[5]=1, ITYPE[5]=1, pin5 pulsed high then low, with ICR written between the edges -> RIS[5] is set again by the falling edge.
REQ-027 SHALL check: ICR clear issued in the same cycle as a new edge on pin3 -> RIS[3] remains 1.
REQ-028 SHALL check: level mode, IPOL[0]=0, pin0 low -> RIS[0]=1; set DIR[0]=1 -> RIS[0]=0; read offset 0x7C -> 0xDEADBEEF.
REQ-029 SHALL check: assert HRESETn low during a DOUT write data phase -> DOUT=0 after reset and the write is lost.
